gate_sweep_ctrl: RTL and testbench
==================================

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; no other clock or reset inputs.
REQ-002 Parameter SHALL be `SETTLE`, default 1, giving settle cycles per row; legal range 1..15.
REQ-003 Port `clk`  in  1  rising-edge clock.
REQ-004 Port `rst_n`  in  1  synchronous active-low reset.
REQ-005 Port `start`  in  1  request a full truth-table sweep.
REQ-006 Port `abort`  in  1  cancel the sweep in progress.
REQ-007 Port `expected`  in  4  expected table; bit i = gate output for {a,b}=i.
REQ-008 Port `gate_out`  in  1  output of the 2-input gate under test.
REQ-009 Port `a`  out  1  gate input a, equal to row[1].
REQ-010 Port `b`  out  1  gate input b, equal to row[0].
REQ-011 Port `busy`  out  1  sweep in progress.
REQ-012 Port `sample_valid`  out  1  one-cycle pulse after each row is captured.
REQ-013 Port `result`  out  4  captured table; bit i = sampled gate_out for row i.
REQ-014 Port `done`  out  1  one-cycle pulse when the sweep completes.
REQ-015 Port `pass`  out  1  result equals expected; valid from done until the next start.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT, DONE. All outputs SHALL be registered.
REQ-017 In IDLE, start=1 and abort=0 SHALL, at the edge: clear result and pass, set row=0 (a=0, b=0), set the settle counter to SETTLE, set busy=1, and go to WAIT.
REQ-018 In WAIT, the counter SHALL decrement each edge. At the edge where the counter equals 1, the block SHALL:
- write gate_out into result[row]
- assert sample_valid for the next cycle
REQ-019 On that sampling edge with row<3, the block SHALL increment row (a and b update on the same edge), reload the counter to SETTLE, and stay in WAIT.
REQ-020 On that sampling edge with row=3, the block SHALL:
- go to DONE
- set a=0, b=0
- set busy=0
- set done=1 for exactly one cycle
- set pass=(result with bit 3 just written == expected)
REQ-021 Latency: with start accepted at edge E0, row k SHALL be sampled at edge E0+(k+1)*SETTLE, and done SHALL be high in the cycle after edge E0+4*SETTLE.
REQ-022 DONE SHALL last one cycle and then go to IDLE; start=1 in the DONE cycle SHALL be accepted as in REQ-017.
REQ-023 start while in WAIT SHALL be ignored.
REQ-024 abort=1 in WAIT SHALL, at the next edge:
- go to IDLE
- set a=0, b=0, busy=0
- clear result and pass
- produce no done and no sample_valid
REQ-025 abort=1 together with start=1 in IDLE or DONE SHALL win: the block goes to or stays in IDLE and the sweep does not start.
REQ-026 result and pass SHALL hold their values in IDLE until the next accepted start or abort.
REQ-027 gate_out SHALL be ignored outside sampling edges.

Reset
REQ-028 rst_n=0 at an edge SHALL force, regardless of state including mid-sweep:
- state=IDLE, row=0, counter=0
- a=0, b=0, busy=0, sample_valid=0, done=0, pass=0, result=4'b0000
REQ-029 start SHALL be ignored while rst_n=0; the first edge with rst_n=1 and start=1 SHALL begin a sweep.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
1. AND gate model, expected=4'b1000, SETTLE=1, start pulse -> {a,b} = 00,01,10,11 on successive cycles; four sample_valid pulses; result=4'b1000; pass=1; done one cycle after edge E0+4.
2. AND gate model, expected=4'b0110 (XOR table), SETTLE=1 -> result=4'b1000, pass=0, done pulses once.
3. Gate model with 2-cycle output delay, expected=4'b1000 -> SETTLE=3 gives pass=1 and done after E0+12; SETTLE=1 gives pass=0.
4. abort raised while row=2 -> next cycle busy=0, a=b=0, result=0, no done ever pulses; a later start runs a full clean sweep.
5. rst_n=0 for one edge during row 1 -> all outputs zero the following cycle; no done until a new start.
6. start held high through a sweep -> ignored while busy; re-accepted in the DONE cycle; second sweep starts immediately with result cleared.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives all four input rows into a 2-input gate,
// samples its output after a settle time and compares the table.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        begin a sweep (ignored while one is running)
//   abort        cancel the running sweep; also clears result/pass
//   expected     expected table, bit i = gate output for {a,b}=i
//   gate_out     output of the gate under test
//   a, b         gate inputs, a=row[1], b=row[0]
//   busy         sweep in progress
//   sample_valid one-cycle pulse after each row is captured
//   result       captured table, bit i = gate_out for row i
//   done         one-cycle pulse when the sweep completes
//   pass         result == expected, valid from done until next start
module gate_sweep_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] expected,
    input  logic       gate_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       sample_valid,
    output logic [3:0] result,
    output logic       done,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] SET = 4'(SETTLE);

    state_t     state;
    logic [1:0] row;
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            row          <= 2'd0;
            cnt          <= 4'd0;
            a            <= 1'b0;
            b            <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            result       <= 4'b0000;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (abort) begin
                        // abort beats start and drops the held table
                        result <= 4'b0000;
                        pass   <= 1'b0;
                    end else if (start) begin
                        result <= 4'b0000;
                        pass   <= 1'b0;
                        row    <= 2'd0;
                        a      <= 1'b0;
                        b      <= 1'b0;
                        cnt    <= SET;
                        busy   <= 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state  <= IDLE;
                        row    <= 2'd0;
                        cnt    <= 4'd0;
                        a      <= 1'b0;
                        b      <= 1'b0;
                        busy   <= 1'b0;
                        result <= 4'b0000;
                        pass   <= 1'b0;
                    end else if (cnt == 4'd1) begin
                        result[row]  <= gate_out;
                        sample_valid <= 1'b1;
                        if (row != 2'd3) begin
                            row    <= row + 2'd1;
                            {a, b} <= row + 2'd1;
                            cnt    <= SET;
                        end else begin
                            state <= DONE;
                            row   <= 2'd0;
                            cnt   <= 4'd0;
                            a     <= 1'b0;
                            b     <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // bit 3 is being written this edge
                            pass  <= ({gate_out, result[2:0]} == expected);
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: scoreboard bench for gate_sweep_ctrl with
// SETTLE=1 (instance 0) and SETTLE=3 (instance 1).
module tb_gate_sweep_ctrl;

    typedef struct {
        bit         is_done;
        int         edge_n;
        logic [3:0] res;
        bit         pas;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] start_i, abort_i, rstn_i;
    logic [7:0] exp_all;
    logic [7:0] res_all;
    logic [1:0] gout, a_o, b_o, busy_o, sv_o, done_o, pass_o;
    logic [1:0] d1, d2;

    logic [3:0] gtt [2];
    int         gd;
    int         e0 [2];
    int         wend [2];
    logic [3:0] idle_res [2];
    bit         idle_pass [2];
    ev_t        q [2][$];
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;

    gate_sweep_ctrl #(.SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rstn_i[0]), .start(start_i[0]),
        .abort(abort_i[0]), .expected(exp_all[3:0]),
        .gate_out(gout[0]), .a(a_o[0]), .b(b_o[0]),
        .busy(busy_o[0]), .sample_valid(sv_o[0]),
        .result(res_all[3:0]), .done(done_o[0]), .pass(pass_o[0])
    );

    gate_sweep_ctrl #(.SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rstn_i[1]), .start(start_i[1]),
        .abort(abort_i[1]), .expected(exp_all[7:4]),
        .gate_out(gout[1]), .a(a_o[1]), .b(b_o[1]),
        .busy(busy_o[1]), .sample_valid(sv_o[1]),
        .result(res_all[7:4]), .done(done_o[1]), .pass(pass_o[1])
    );

    // gate under test: truth table gtt, optional 2-flop output delay
    always @(posedge clk) begin
        d1[0] <= gtt[0][{a_o[0], b_o[0]}];
        d1[1] <= gtt[1][{a_o[1], b_o[1]}];
        d2    <= d1;
    end
    assign gout[0] = (gd == 0) ? gtt[0][{a_o[0], b_o[0]}] : d2[0];
    assign gout[1] = (gd == 0) ? gtt[1][{a_o[1], b_o[1]}] : d2[1];

    function automatic void chk(string nm, int i, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] @cyc %0d: got %0h expected %0h",
                     nm, i, cyc, act, exp);
        end
    endfunction

    function automatic int settle(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit in_wait(int i, int n);
        return e0[i] >= 0 && n >= e0[i] && n < wend[i];
    endfunction

    // Row k is sampled at E0+(k+1)*S; the gate shows the row that was
    // applied gd+1 cycles earlier (a=b=0 before the sweep).
    function automatic bit sampled(int i, int k);
        int s = settle(i);
        int j = (k + 1) * s - (gd + 1);
        int r = (j < 0) ? 0 : j / s;
        return gtt[i][r];
    endfunction

    task automatic model(int i, int e, bit st, bit ab, bit rs);
        bit         inw;
        logic [3:0] r;
        ev_t        ev;
        int         s;
        inw = in_wait(i, e - 1);
        s   = settle(i);
        r   = 4'b0000;
        if (!rs || ab) begin
            if (inw) wend[i] = e;
            while (q[i].size() > 0 && q[i][$].edge_n >= e)
                void'(q[i].pop_back());
            idle_res[i]  = 4'b0000;
            idle_pass[i] = 1'b0;
        end else if (st && !inw) begin
            e0[i]   = e;
            wend[i] = e + 4 * s;
            for (int k = 0; k < 4; k++) begin
                r[k]      = sampled(i, k);
                ev.is_done = 1'b0;
                ev.edge_n  = e + (k + 1) * s;
                ev.res     = r;
                ev.pas     = 1'b0;
                q[i].push_back(ev);
            end
            ev.is_done = 1'b1;
            ev.edge_n  = e + 4 * s;
            ev.res     = r;
            ev.pas     = (r == exp_all[i*4 +: 4]);
            q[i].push_back(ev);
        end
    endtask

    task automatic mon_step(int i, int n);
        bit         esv, ed, inw;
        logic [3:0] r;
        logic [1:0] eab;
        r   = res_all[i*4 +: 4];
        esv = q[i].size() > 0 && q[i][0].edge_n == n && !q[i][0].is_done;
        chk("sample_valid", i, int'(sv_o[i]), int'(esv));
        if (esv) begin
            chk("sv_result", i, int'(r), int'(q[i][0].res));
            void'(q[i].pop_front());
        end
        ed = q[i].size() > 0 && q[i][0].edge_n == n && q[i][0].is_done;
        chk("done", i, int'(done_o[i]), int'(ed));
        if (ed) begin
            chk("done_result", i, int'(r), int'(q[i][0].res));
            chk("done_pass", i, int'(pass_o[i]), int'(q[i][0].pas));
            idle_res[i]  = q[i][0].res;
            idle_pass[i] = q[i][0].pas;
            void'(q[i].pop_front());
        end
        while (q[i].size() > 0 && q[i][0].edge_n < n)
            void'(q[i].pop_front());
        inw = in_wait(i, n);
        eab = inw ? 2'((n - e0[i]) / settle(i)) : 2'b00;
        chk("busy", i, int'(busy_o[i]), int'(inw));
        chk("ab", i, int'({a_o[i], b_o[i]}), int'(eab));
        if (!inw) begin
            chk("hold_result", i, int'(r), int'(idle_res[i]));
            chk("hold_pass", i, int'(pass_o[i]), int'(idle_pass[i]));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) mon_step(i, cyc);
        end
    end

    task automatic tick(int i, bit st, bit ab, bit rs);
        @(negedge clk);
        #1;
        start_i    = 2'b00;
        abort_i    = 2'b00;
        rstn_i     = 2'b11;
        start_i[i] = st;
        abort_i[i] = ab;
        rstn_i[i]  = rs;
        model(i, cyc + 1, st, ab, rs);
    endtask

    task automatic idle(int n);
        repeat (n) tick(0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic set_case(int i, logic [3:0] g, logic [3:0] ex);
        gtt[i]           = g;
        exp_all[i*4 +: 4] = ex;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  i, r;
        bit  st, ab, rs;
        e0        = '{-1, -1};
        wend      = '{-1, -1};
        idle_res  = '{4'b0000, 4'b0000};
        idle_pass = '{1'b0, 1'b0};
        gd        = 0;
        gtt       = '{4'b1000, 4'b1000};
        exp_all   = 8'h88;
        start_i   = 2'b00;
        abort_i   = 2'b00;
        rstn_i    = 2'b00;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        idle(3);

        // AND gate, matching table
        set_case(0, 4'b1000, 4'b1000);
        tick(0, 1, 0, 1);
        idle(6);

        // AND gate against XOR table
        set_case(0, 4'b1000, 4'b0110);
        tick(0, 1, 0, 1);
        idle(6);

        // gate with 2-cycle delay: SETTLE=3 passes, SETTLE=1 fails
        gd = 2;
        set_case(0, 4'b1000, 4'b1000);
        set_case(1, 4'b1000, 4'b1000);
        idle(4);
        tick(1, 1, 0, 1);
        idle(14);
        tick(0, 1, 0, 1);
        idle(6);
        gd = 0;
        idle(3);

        // abort at row 2, then a clean sweep
        tick(0, 1, 0, 1);
        idle(2);
        tick(0, 0, 1, 1);
        idle(6);
        tick(0, 1, 0, 1);
        idle(6);
        tick(1, 1, 0, 1);
        idle(6);
        tick(1, 0, 1, 1);
        idle(4);
        tick(1, 1, 0, 1);
        idle(14);

        // reset during row 1, then a new sweep
        tick(1, 1, 0, 1);
        idle(3);
        tick(1, 0, 0, 0);
        idle(16);
        tick(1, 1, 0, 1);
        idle(14);

        // start held high across two sweeps
        set_case(0, 4'b0110, 4'b0110);
        repeat (10) tick(0, 1, 0, 1);
        idle(6);

        // abort together with start while idle
        tick(0, 1, 1, 1);
        tick(1, 1, 1, 1);
        idle(4);

        // random traffic
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < 2; k++) begin
                logic [3:0] g;
                g = 4'($urandom_range(0, 15));
                set_case(k, g, ($urandom_range(0, 1) == 1) ? g
                                 : 4'($urandom_range(0, 15)));
            end
            repeat (20) begin
                i  = int'($urandom_range(0, 1));
                r  = int'($urandom_range(0, 99));
                st = (r < 30);
                ab = (r >= 30 && r < 35);
                rs = !(r >= 35 && r < 37);
                tick(i, st, ab, rs);
            end
            idle(15);
        end

        idle(5);
        chk("queue_empty", 0, q[0].size(), 0);
        chk("queue_empty", 1, q[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
